// File: rtl/sram_like_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_like_defs (package)                                        |
// | Purpose  : Shared definitions for the sram-like arbiter slice: transfer    |
// |            size encodings, fixed channel assignments and the channel-ID    |
// |            width helper used to size the outstanding-ID FIFO.              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

// Width of a channel ID for n channels; a single channel still needs one bit
`ifndef SRAM_LIKE_CH_ID_W
`define SRAM_LIKE_CH_ID_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package sram_like_defs;

   // Transfer size encoding carried on m_size / s_size
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;

   // Channel roles in the default two-channel CPU configuration
   localparam int CH_INST = 0;
   localparam int CH_DATA = 1;

   function automatic int ch_id_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_like_id_fifo                                               |
// | Purpose  : Synchronous FIFO holding the issuing-channel ID of every        |
// |            accepted, not yet answered transaction. Head is read            |
// |            combinationally so the response can be steered in the same      |
// |            cycle the slave returns it.                                     |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            push/din   - write one entry (ignored while full)               |
// |            pop        - drop head entry (ignored while empty)              |
// |            head       - oldest entry                                       |
// |            full/empty/count - occupancy                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sram_like_id_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   // A depth-1 FIFO still gets a 1-bit pointer that simply stays at zero
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic do_push;
   logic do_pop;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];

   assign do_push = push && !full;
   assign do_pop  = pop  && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end

      // Simultaneous push and pop leave the occupancy unchanged
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it was written
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_like_arbiter                                               |
// | Purpose  : Merges NUM_CH sram-like master channels (ch0 instruction fetch, |
// |            ch1 data by default) onto one sram-like slave port. Requests    |
// |            are arbitrated combinationally, a stalled winner is locked      |
// |            until the slave accepts it, and the issuing channel of every    |
// |            accepted request is queued so in-order responses are routed     |
// |            back to the right master.                                       |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            m_req/m_wr/m_size/m_addr/m_wdata/m_wstrb - packed master        |
// |                 requests, ch0 in the LSBs                                  |
// |            m_addr_ok/m_data_ok - one-hot accept / response per channel     |
// |            m_rdata  - shared read data, qualified by m_data_ok             |
// |            s_req/s_wr/s_size/s_addr/s_wdata/s_wstrb - muxed slave request  |
// |            s_addr_ok/s_data_ok/s_rdata - slave handshake and read data     |
// | Options  : SRAM_LIKE_ARB_RR_EN      - round-robin instead of fixed priority|
// |            SRAM_LIKE_ARB_SIM_CHECKS - simulation $error on a response      |
// |                                       arriving with nothing outstanding    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sram_like_arbiter
   import sram_like_defs::*;
#(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic                          clk,
   input  logic                          reset,

   input  logic [NUM_CH-1:0]             m_req,
   input  logic [NUM_CH-1:0]             m_wr,
   input  logic [2*NUM_CH-1:0]           m_size,
   input  logic [ADDR_W*NUM_CH-1:0]      m_addr,
   input  logic [DATA_W*NUM_CH-1:0]      m_wdata,
   input  logic [(DATA_W/8)*NUM_CH-1:0]  m_wstrb,
   output logic [NUM_CH-1:0]             m_addr_ok,
   output logic [NUM_CH-1:0]             m_data_ok,
   output logic [DATA_W-1:0]             m_rdata,

   output logic                          s_req,
   output logic                          s_wr,
   output logic [1:0]                    s_size,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [DATA_W/8-1:0]           s_wstrb,
   input  logic                          s_addr_ok,
   input  logic                          s_data_ok,
   input  logic [DATA_W-1:0]             s_rdata
);

   localparam int ID_W   = `SRAM_LIKE_CH_ID_W(NUM_CH);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(MAX_OUTST + 1);

   // ------------------------------------------------------------------
   // Grant lock state
   // ------------------------------------------------------------------
   logic            lock_q,    lock_d;
   logic [ID_W-1:0] lock_id_q, lock_id_d;

   logic [ID_W-1:0] win_id;
   logic [ID_W-1:0] sel_id;
   logic            any_req;
   logic            accept;

   // ------------------------------------------------------------------
   // ID FIFO interface
   // ------------------------------------------------------------------
   logic            fifo_pop;
   logic [ID_W-1:0] fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic            unused_fifo_count;

   assign unused_fifo_count = ^fifo_count;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
`ifdef SRAM_LIKE_ARB_RR_EN
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   // Search order starts at rr_ptr; scanning offsets from the far end
   // backwards lets the closest requester overwrite earlier candidates.
   always_comb begin
      win_id = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if ((((int'(rr_ptr_q) + k) % NUM_CH) == i) && m_req[i]) begin
               win_id = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (sel_id == ID_W'(NUM_CH - 1)) ? '0 : sel_id + ID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   // Fixed priority: the lowest-index requester is assigned last and wins
   always_comb begin
      win_id = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m_req[i]) begin
            win_id = ID_W'(i);
         end
      end
   end
`endif

   // A stalled winner keeps the bus until the slave takes it, so a newly
   // arriving higher-priority request cannot swap fields under the slave.
   assign sel_id  = lock_q ? lock_id_q : win_id;
   assign any_req = |m_req;
   assign s_req   = !reset && any_req && !fifo_full;
   assign accept  = s_req && s_addr_ok;

   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (accept) begin
         lock_d = 1'b0;
      end else if (s_req) begin
         lock_d    = 1'b1;
         lock_id_d = sel_id;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   // ------------------------------------------------------------------
   // Request mux toward the slave
   // ------------------------------------------------------------------
   always_comb begin
      s_wr    = 1'b0;
      s_size  = 2'(SIZE_BYTE);
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_id == ID_W'(i)) begin
            s_wr    = m_wr[i];
            s_size  = m_size[i*2 +: 2];
            s_addr  = m_addr[i*ADDR_W +: ADDR_W];
            s_wdata = m_wdata[i*DATA_W +: DATA_W];
            s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
         end
      end
   end

   // ------------------------------------------------------------------
   // Accept / response steering
   // ------------------------------------------------------------------
   // A response with nothing outstanding has no owner and is dropped
   assign fifo_pop = !reset && s_data_ok && !fifo_empty;
   assign m_rdata  = s_rdata;

   always_comb begin
      m_addr_ok = '0;
      m_data_ok = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_addr_ok[i] = accept   && (sel_id    == ID_W'(i));
         m_data_ok[i] = fifo_pop && (fifo_head == ID_W'(i));
      end
   end

   sram_like_id_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .din   (sel_id),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef SRAM_LIKE_ARB_SIM_CHECKS
   always_ff @(posedge clk) begin
      if (!reset && s_data_ok && fifo_empty) begin
         $error("sram_like_arbiter: s_data_ok with no outstanding transaction");
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_like_arbiter                                            |
// | Purpose  : Self-checking bench for sram_like_arbiter. A cycle table drives |
// |            masters and slave handshake and lists the expected outputs;     |
// |            hand-written sequences cover reset mid-flight and continuous    |
// |            contention (fixed priority or SRAM_LIKE_ARB_RR_EN round-robin). |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sram_like_arbiter;

   localparam int NUM_CH    = 2;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_OUTST = 4;
   localparam int STRB_W    = DATA_W / 8;

`ifdef SRAM_LIKE_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // Fixed per-channel request fields: ch0 word read, ch1 byte write
   localparam logic [31:0] A0  = 32'hBFC0_0000;
   localparam logic [31:0] A1  = 32'h8000_1000;
   localparam logic [31:0] WD1 = 32'hDEAD_BEEF;

   logic                        clk = 1'b0;
   logic                        reset;
   logic [NUM_CH-1:0]           m_req;
   logic [NUM_CH-1:0]           m_wr;
   logic [2*NUM_CH-1:0]         m_size;
   logic [ADDR_W*NUM_CH-1:0]    m_addr;
   logic [DATA_W*NUM_CH-1:0]    m_wdata;
   logic [STRB_W*NUM_CH-1:0]    m_wstrb;
   logic [NUM_CH-1:0]           m_addr_ok;
   logic [NUM_CH-1:0]           m_data_ok;
   logic [DATA_W-1:0]           m_rdata;
   logic                        s_req;
   logic                        s_wr;
   logic [1:0]                  s_size;
   logic [ADDR_W-1:0]           s_addr;
   logic [DATA_W-1:0]           s_wdata;
   logic [STRB_W-1:0]           s_wstrb;
   logic                        s_addr_ok;
   logic                        s_data_ok;
   logic [DATA_W-1:0]           s_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(
      .NUM_CH    (NUM_CH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .m_req     (m_req),
      .m_wr      (m_wr),
      .m_size    (m_size),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_addr_ok (m_addr_ok),
      .m_data_ok (m_data_ok),
      .m_rdata   (m_rdata),
      .s_req     (s_req),
      .s_wr      (s_wr),
      .s_size    (s_size),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_addr_ok (s_addr_ok),
      .s_data_ok (s_data_ok),
      .s_rdata   (s_rdata)
   );

   typedef struct {
      logic [1:0]  req;
      logic        sao;
      logic        sdo;
      logic [31:0] rdata;
      logic        e_sreq;
      int          e_ch;
      logic [1:0]  e_aok;
      logic [1:0]  e_dok;
      int          e_cnt;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic [1:0] req, input logic sao, input logic sdo,
                               input logic [31:0] rd, input logic esreq, input int ech,
                               input logic [1:0] eaok, input logic [1:0] edok, input int ecnt);
      vec_t v;
      v.req = req; v.sao = sao; v.sdo = sdo; v.rdata = rd;
      v.e_sreq = esreq; v.e_ch = ech; v.e_aok = eaok; v.e_dok = edok; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Check the muxed request fields against the selected channel's constants
   task automatic chk_fields(input string tag, input int ch);
      chk({tag, " s_addr"},  s_addr,           (ch == 0) ? A0 : A1);
      chk({tag, " s_wr"},    32'(s_wr),        (ch == 0) ? 32'd0 : 32'd1);
      chk({tag, " s_size"},  32'(s_size),      (ch == 0) ? 32'd2 : 32'd0);
      chk({tag, " s_wdata"}, s_wdata,          (ch == 0) ? 32'd0 : WD1);
      chk({tag, " s_wstrb"}, 32'(s_wstrb),     (ch == 0) ? 32'hF : 32'h1);
   endtask

   task automatic drive(input logic [1:0] req, input logic sao, input logic sdo,
                        input logic [31:0] rd);
      m_req     = req;
      s_addr_ok = sao;
      s_data_ok = sdo;
      s_rdata   = rd;
   endtask

   logic [1:0] grants [4];

   initial begin
      // Contention vectors depend on arbitration policy; everything else is common
      vecs[0]  = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 0);
      vecs[1]  = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1);
      vecs[2]  = mk(2'b00, 0, 1, 32'h3C08_0001, 0, 0, 2'b00, 2'b01, 1);
      vecs[3]  = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0);
      if (!RR) begin
         vecs[4] = mk(2'b11, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 0);
         vecs[5] = mk(2'b10, 1, 0, 32'h0,         1, 1, 2'b10, 2'b00, 1);
         vecs[6] = mk(2'b00, 0, 1, 32'hAAAA_0000, 0, 0, 2'b00, 2'b01, 2);
         vecs[7] = mk(2'b00, 0, 1, 32'h5555_FFFF, 0, 0, 2'b00, 2'b10, 1);
      end else begin
         // rr_ptr is 1 after the ch0 accept above, so ch1 goes first
         vecs[4] = mk(2'b11, 1, 0, 32'h0,         1, 1, 2'b10, 2'b00, 0);
         vecs[5] = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 1);
         vecs[6] = mk(2'b00, 0, 1, 32'hAAAA_0000, 0, 0, 2'b00, 2'b10, 2);
         vecs[7] = mk(2'b00, 0, 1, 32'h5555_FFFF, 0, 0, 2'b00, 2'b01, 1);
      end
      vecs[8]  = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0);
      // Lock: ch1 stalls three cycles, ch0 joins but must not preempt
      vecs[9]  = mk(2'b10, 0, 0, 32'h0,         1, 1, 2'b00, 2'b00, 0);
      vecs[10] = mk(2'b11, 0, 0, 32'h0,         1, 1, 2'b00, 2'b00, 0);
      vecs[11] = mk(2'b11, 0, 0, 32'h0,         1, 1, 2'b00, 2'b00, 0);
      vecs[12] = mk(2'b11, 1, 0, 32'h0,         1, 1, 2'b10, 2'b00, 0);
      vecs[13] = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 1);
      vecs[14] = mk(2'b00, 0, 1, 32'h1111_1111, 0, 0, 2'b00, 2'b10, 2);
      vecs[15] = mk(2'b00, 0, 1, 32'h2222_2222, 0, 0, 2'b00, 2'b01, 1);
      vecs[16] = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0);
      // Full: four accepts, fifth request blocked, pop frees slot next cycle
      vecs[17] = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 0);
      vecs[18] = mk(2'b10, 1, 0, 32'h0,         1, 1, 2'b10, 2'b00, 1);
      vecs[19] = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 2);
      vecs[20] = mk(2'b10, 1, 0, 32'h0,         1, 1, 2'b10, 2'b00, 3);
      vecs[21] = mk(2'b01, 1, 0, 32'h0,         0, 0, 2'b00, 2'b00, 4);
      vecs[22] = mk(2'b01, 1, 1, 32'h0000_A001, 0, 0, 2'b00, 2'b01, 4);
      vecs[23] = mk(2'b01, 1, 0, 32'h0,         1, 0, 2'b01, 2'b00, 3);
      vecs[24] = mk(2'b00, 0, 1, 32'h0000_B002, 0, 0, 2'b00, 2'b10, 4);
      vecs[25] = mk(2'b00, 0, 1, 32'h0000_C003, 0, 0, 2'b00, 2'b01, 3);
      // Simultaneous push and pop at count 2
      vecs[26] = mk(2'b10, 1, 1, 32'h0000_D004, 1, 1, 2'b10, 2'b10, 2);
      vecs[27] = mk(2'b00, 0, 1, 32'h0000_E005, 0, 0, 2'b00, 2'b01, 2);
      vecs[28] = mk(2'b00, 0, 1, 32'h0000_F006, 0, 0, 2'b00, 2'b10, 1);
      vecs[29] = mk(2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0);
      // Stray response with nothing outstanding
      vecs[30] = mk(2'b00, 0, 1, 32'hDEAD_0BAD, 0, 0, 2'b00, 2'b00, 0);

      m_wr    = 2'b10;
      m_size  = {2'd0, 2'd2};
      m_addr  = {A1, A0};
      m_wdata = {WD1, 32'h0};
      m_wstrb = {4'h1, 4'hF};

      // Reset state: outputs forced low while reset is high
      reset = 1'b1;
      drive(2'b11, 1, 1, 32'h1234_5678);
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("rst s_req",     32'(s_req),      32'd0);
      chk("rst m_addr_ok", 32'(m_addr_ok),  32'd0);
      chk("rst m_data_ok", 32'(m_data_ok),  32'd0);
      chk("rst count",     32'(dut.fifo_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b00, 0, 0, 32'h0);
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         drive(vecs[i].req, vecs[i].sao, vecs[i].sdo, vecs[i].rdata);
         #2;
         chk({tag, " count"},     32'(dut.fifo_count), 32'(vecs[i].e_cnt));
         chk({tag, " s_req"},     32'(s_req),          32'(vecs[i].e_sreq));
         if (vecs[i].e_sreq) chk_fields(tag, vecs[i].e_ch);
         chk({tag, " m_addr_ok"}, 32'(m_addr_ok),      32'(vecs[i].e_aok));
         chk({tag, " m_data_ok"}, 32'(m_data_ok),      32'(vecs[i].e_dok));
         if (vecs[i].e_dok != 2'b00) chk({tag, " m_rdata"}, m_rdata, vecs[i].rdata);
         @(negedge clk);
      end

      // Reset mid-flight with three outstanding
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 1, 0, 32'h0);
         #2;
         chk($sformatf("mr accept%0d", i), 32'(m_addr_ok), 32'd1);
         @(negedge clk);
      end
      drive(2'b01, 1, 1, 32'h7777_7777);
      #2;
      chk("mr pre count",  32'(dut.fifo_count), 32'd3);
      chk("mr pre dok",    32'(m_data_ok),      32'd1);
      reset = 1'b1;
      #1;
      chk("mr rst s_req",  32'(s_req),     32'd0);
      chk("mr rst aok",    32'(m_addr_ok), 32'd0);
      chk("mr rst dok",    32'(m_data_ok), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b00, 0, 0, 32'h0);
      #2;
      chk("mr post count", 32'(dut.fifo_count), 32'd0);
      chk("mr post s_req", 32'(s_req),     32'd0);
      chk("mr post dok",   32'(m_data_ok), 32'd0);
      @(negedge clk);
      drive(2'b00, 0, 1, 32'h0BAD_0BAD);
      #2;
      chk("mr stray dok",  32'(m_data_ok), 32'd0);
      @(negedge clk);

      // Continuous contention from a fresh rr pointer
      for (int i = 0; i < 4; i++) begin
         grants[i] = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
      end
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 1, 0, 32'h0);
         #2;
         chk($sformatf("cc grant%0d", i), 32'(m_addr_ok), 32'(grants[i]));
         @(negedge clk);
      end
      drive(2'b11, 1, 0, 32'h0);
      #2;
      chk("cc full s_req", 32'(s_req), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 0, 1, 32'hC0DE_0000 + 32'(i));
         #2;
         chk($sformatf("cc resp%0d", i),  32'(m_data_ok), 32'(grants[i]));
         chk($sformatf("cc rdata%0d", i), m_rdata,        32'hC0DE_0000 + 32'(i));
         @(negedge clk);
      end
      drive(2'b00, 0, 0, 32'h0);
      #2;
      chk("cc drained", 32'(dut.fifo_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
